// File: rtl/ad9945_pkg.sv
// Shared constants for the AD9945 serial configuration receiver:
// field widths, register address map and FSM state encoding.
package ad9945_pkg;

  localparam int ADDR_BITS_DEF = 3;
  localparam int DATA_BITS_DEF = 12;

  localparam int ADDR_OPER  = 0;
  localparam int ADDR_CTRL  = 1;
  localparam int ADDR_CLAMP = 2;
  localparam int ADDR_VGA   = 3;
  localparam int ADDR_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/ad9945_sync.sv
// Multi-flop synchronizer followed by a one-flop edge detector.
// RESET_VAL sets the idle level so reset release never creates an edge.
module ad9945_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;

  // synchronizer chain plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{RESET_VAL}};
      prev_r  <= RESET_VAL;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= chain_r[STAGES-1];
    end
  end

  assign level = chain_r[STAGES-1];
  assign rise  = chain_r[STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/ad9945_spi_rx.sv
// AD9945 serial configuration receiver: LSB-first address/data frames into
// four control registers. Define AD9945_SPI_RX_ERRCNT_EN to add err_cnt.
module ad9945_spi_rx
  import ad9945_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 SCK,
  input  logic                 SL,
  input  logic                 SDATA,
  output logic [6:0]           Oper,
  output logic [6:0]           Ctrl,
  output logic [7:0]           Clamp,
  output logic [9:0]           VGA_Gain,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 busy
`ifdef AD9945_SPI_RX_ERRCNT_EN
  ,output logic [7:0]          err_cnt
`endif
);

  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic sl_level_s, sl_rise_s, sl_fall_s;
  logic sdata_level_s, sdata_rise_s, sdata_fall_s;

  ad9945_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(sys_clk), .rst_n(rst_n), .din(SCK),
    .level(sck_level_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  ad9945_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sl (
    .clk(sys_clk), .rst_n(rst_n), .din(SL),
    .level(sl_level_s), .rise(sl_rise_s), .fall(sl_fall_s)
  );

  ad9945_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdata (
    .clk(sys_clk), .rst_n(rst_n), .din(SDATA),
    .level(sdata_level_s), .rise(sdata_rise_s), .fall(sdata_fall_s)
  );

  logic unused_s;
  assign unused_s = ^{sck_level_s, sck_fall_s, sdata_rise_s, sdata_fall_s};

  state_t                  state_r, next_state_s;
  logic [SYNC_STAGES-1:0]  settle_r;
  logic                    arm_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [ADDR_BITS-1:0]    addr_s;
  logic [DATA_BITS-1:0]    data_s;
  logic                    frame_ok_s;
  logic                    start_s, shift_en_s, commit_s, reject_s;
  logic [6:0]              oper_r, ctrl_r;
  logic [7:0]              clamp_r;
  logic [9:0]              vga_r;
  logic                    wr_valid_r, frame_err_r, busy_r;
  logic [ADDR_BITS-1:0]    wr_addr_r;
  logic [DATA_BITS-1:0]    wr_data_r;

  assign addr_s     = shift_r[ADDR_BITS-1:0];
  assign data_s     = shift_r[FRAME_BITS-1:ADDR_BITS];
  assign frame_ok_s = (bit_cnt_r == CNT_FULL) && (32'(addr_s) < ADDR_COUNT);

  // SL must be seen high with a settled synchronizer before a falling edge can start a frame
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_r <= '0;
      arm_r    <= 1'b0;
    end else begin
      settle_r <= {settle_r[SYNC_STAGES-2:0], 1'b1};
      arm_r    <= arm_r | (settle_r[SYNC_STAGES-1] & sl_level_s);
    end
  end

  // state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state decode; an SL rise masks a coincident SCK rise
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    shift_en_s   = 1'b0;
    commit_s     = 1'b0;
    reject_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sl_fall_s && arm_r) begin
          next_state_s = ST_SHIFT;
          start_s      = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sl_rise_s) begin
          next_state_s = ST_COMMIT;
          if (frame_ok_s) begin
            commit_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else begin
          shift_en_s = sck_rise_s;
        end
      end
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // frame shift register and saturating bit counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else if (start_s) begin
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else if (shift_en_s) begin
      shift_r <= {sdata_level_s, shift_r[FRAME_BITS-1:1]};
      if (bit_cnt_r != CNT_SAT) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end
  end

  // commit results become visible for exactly the COMMIT cycle
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      oper_r      <= 7'd0;
      ctrl_r      <= 7'd0;
      clamp_r     <= 8'd0;
      vga_r       <= 10'd0;
      wr_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      busy_r      <= 1'b0;
    end else begin
      wr_valid_r  <= commit_s;
      frame_err_r <= reject_s;
      busy_r      <= (next_state_s == ST_SHIFT);
      if (commit_s) begin
        wr_addr_r <= addr_s;
        wr_data_r <= data_s;
        case (32'(addr_s))
          ADDR_OPER:  oper_r  <= data_s[6:0];
          ADDR_CTRL:  ctrl_r  <= data_s[6:0];
          ADDR_CLAMP: clamp_r <= data_s[7:0];
          ADDR_VGA:   vga_r   <= data_s[9:0];
          default:    oper_r  <= oper_r;
        endcase
      end
    end
  end

  assign Oper      = oper_r;
  assign Ctrl      = ctrl_r;
  assign Clamp     = clamp_r;
  assign VGA_Gain  = vga_r;
  assign wr_valid  = wr_valid_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

`ifdef AD9945_SPI_RX_ERRCNT_EN
  logic [7:0] err_cnt_r;

  // saturating rejected-frame counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if (reject_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_ad9945_spi_rx.sv
// Directed bench for ad9945_spi_rx with a write scoreboard.
// Define AD9945_SPI_RX_ERRCNT_EN to also exercise err_cnt.
module tb_ad9945_spi_rx;

  logic        sys_clk;
  logic        rst_n;
  logic        SCK, SL, SDATA;
  logic [6:0]  Oper, Ctrl;
  logic [7:0]  Clamp;
  logic [9:0]  VGA_Gain;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_err;
  logic        busy;
`ifdef AD9945_SPI_RX_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  ad9945_spi_rx dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .SCK(SCK), .SL(SL), .SDATA(SDATA),
    .Oper(Oper), .Ctrl(Ctrl), .Clamp(Clamp), .VGA_Gain(VGA_Gain),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
`ifdef AD9945_SPI_RX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0]  a;
    logic [11:0] d;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_wr  = 0;
  int  n_err = 0;
  int  wr0, err0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // pulse counters for the whole run
  always @(negedge sys_clk) begin
    if (wr_valid === 1'b1) n_wr++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input bit expect_ok);
    bit  seen;
    wr_t e;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (wr_valid === 1'b1 || frame_err === 1'b1) seen = 1'b1;
    end
    if (expect_ok) begin
      chk("wr_valid", 32'(wr_valid), 32'd1);
      chk("no_err_on_good", 32'(frame_err), 32'd0);
      if (wr_valid === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end else begin
      chk("frame_err", 32'(frame_err), 32'd1);
      chk("no_wr_on_bad", 32'(wr_valid), 32'd0);
    end
    @(negedge sys_clk);
    chk("pulse_width", 32'({wr_valid, frame_err}), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] bits, input bit expect_ok);
    if (expect_ok) sb_q.push_back({bits[2:0], bits[14:3]});
    SL = 1'b0;
    repeat (6) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      SDATA = bits[i];
      SCK   = 1'b0;
      repeat (6) @(negedge sys_clk);
      SCK = 1'b1;
      repeat (6) @(negedge sys_clk);
      if (i == 0) chk("busy_in_frame", 32'(busy), 32'd1);
    end
    SCK = 1'b0;
    repeat (6) @(negedge sys_clk);
    SL = 1'b1;
    wait_result(expect_ok);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_regs(input string tag, input logic [6:0] o, input logic [6:0] c,
                            input logic [7:0] cl, input logic [9:0] v);
    chk({tag, "_oper"},  32'(Oper),     32'(o));
    chk({tag, "_ctrl"},  32'(Ctrl),     32'(c));
    chk({tag, "_clamp"}, 32'(Clamp),    32'(cl));
    chk({tag, "_vga"},   32'(VGA_Gain), 32'(v));
  endtask

  initial begin
    rst_n = 1'b0; SCK = 1'b0; SL = 1'b1; SDATA = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_regs("reset", 7'd0, 7'd0, 8'd0, 10'd0);
    chk("reset_wr_valid", 32'(wr_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    // single VGA write
    send_frame(15, {17'd0, 12'h2A5, 3'd3}, 1'b1);
    check_regs("vga_only", 7'd0, 7'd0, 8'd0, 10'h2A5);

    // four back-to-back writes; upper data bits beyond the field are ignored
    wr0 = n_wr; err0 = n_err;
    send_frame(15, {17'd0, 12'hA55, 3'd0}, 1'b1);
    send_frame(15, {17'd0, 12'h02A, 3'd1}, 1'b1);
    send_frame(15, {17'd0, 12'h0C3, 3'd2}, 1'b1);
    send_frame(15, {17'd0, 12'hFFF, 3'd3}, 1'b1);
    check_regs("four", 7'h55, 7'h2A, 8'hC3, 10'h3FF);
    chk("four_wr_pulses", 32'(n_wr - wr0), 32'd4);
    chk("four_err_pulses", 32'(n_err - err0), 32'd0);

    // short, over-length and out-of-map frames
    wr0 = n_wr; err0 = n_err;
    send_frame(14, {17'd0, 12'h001, 3'd0}, 1'b0);
    send_frame(16, {16'd0, 1'b1, 12'h001, 3'd1}, 1'b0);
    send_frame(15, {17'd0, 12'h0FF, 3'd5}, 1'b0);
    check_regs("bad", 7'h55, 7'h2A, 8'hC3, 10'h3FF);
    chk("bad_err_pulses", 32'(n_err - err0), 32'd3);
    chk("bad_wr_pulses", 32'(n_wr - wr0), 32'd0);
`ifdef AD9945_SPI_RX_ERRCNT_EN
    chk("err_cnt_3", 32'(err_cnt), 32'd3);
`endif

    // reset in the middle of a frame, SL still low at release
    wr0 = n_wr; err0 = n_err;
    SL = 1'b0;
    repeat (6) @(negedge sys_clk);
    for (int i = 0; i < 7; i++) begin
      SDATA = i[0];
      SCK = 1'b0; repeat (6) @(negedge sys_clk);
      SCK = 1'b1; repeat (6) @(negedge sys_clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b0; repeat (6) @(negedge sys_clk);
      SCK = 1'b1; repeat (6) @(negedge sys_clk);
    end
    SCK = 1'b0;
    repeat (6) @(negedge sys_clk);
    chk("rst_busy_sl_low", 32'(busy), 32'd0);
    SL = 1'b1;
    repeat (15) @(negedge sys_clk);
    check_regs("midrst", 7'd0, 7'd0, 8'd0, 10'd0);
    chk("midrst_wr_pulses", 32'(n_wr - wr0), 32'd0);
    chk("midrst_err_pulses", 32'(n_err - err0), 32'd0);
    send_frame(15, {17'd0, 12'h081, 3'd2}, 1'b1);
    check_regs("after_rst", 7'd0, 7'd0, 8'h81, 10'd0);

    // SCK activity with SL high is ignored
    wr0 = n_wr; err0 = n_err;
    for (int i = 0; i < 6; i++) begin
      SDATA = 1'($urandom_range(0, 1));
      SCK = 1'b1; repeat (6) @(negedge sys_clk);
      SCK = 1'b0; repeat (6) @(negedge sys_clk);
    end
    repeat (10) @(negedge sys_clk);
    chk("idle_sck_busy", 32'(busy), 32'd0);
    chk("idle_sck_pulses", 32'((n_wr - wr0) + (n_err - err0)), 32'd0);
    send_frame(15, {17'd0, 12'h011, 3'd0}, 1'b1);
    check_regs("idle_sck", 7'h11, 7'd0, 8'h81, 10'd0);
    chk("idle_sck_wr_pulses", 32'(n_wr - wr0), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef AD9945_SPI_RX_ERRCNT_EN
    // 300 empty frames saturate the error counter
    for (int i = 0; i < 300; i++) begin
      SL = 1'b0; repeat (6) @(negedge sys_clk);
      SL = 1'b1; repeat (8) @(negedge sys_clk);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    check_regs("sat", 7'h11, 7'd0, 8'h81, 10'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ad9945_spi_rx.md
AD9945_SPI_RX -- requirements
Module: ad9945_spi_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on SCK/SL/SDATA (min 2).
REQ-002 Parameter: ADDR_BITS, default 3, width of the address field.
REQ-003 Parameter: DATA_BITS, default 12, width of the data field.
REQ-004 Port: sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: SCK  in  1  serial clock from the configuration master; asynchronous to sys_clk.
REQ-007 Port: SL  in  1  frame strobe, active-low.
REQ-008 Port: SDATA  in  1  serial data, LSB first, sampled on SCK rising edge.
REQ-009 Ports: Oper  out  7, Ctrl  out  7, Clamp  out  8, VGA_Gain  out  10; decoded register contents.
REQ-010 Ports: wr_valid  out  1, wr_addr  out  ADDR_BITS, wr_data  out  DATA_BITS; single-cycle write report.
REQ-011 Port: frame_err  out  1  single-cycle pulse on a rejected frame.
REQ-012 Port: busy  out  1  high while a frame is being shifted.

Function
REQ-013 SCK, SL and SDATA shall each pass through SYNC_STAGES flops, then a one-flop edge detector (sub-module ad9945_sync).
REQ-014 SCK period shall be at least 8 sys_clk periods; faster SCK is out of scope, with no defined behaviour.
REQ-015 FSM states: IDLE, SHIFT, COMMIT.
REQ-016 IDLE -> SHIFT on a synchronized SL falling edge; bit counter and shift register are cleared.
REQ-017 In SHIFT, each synchronized SCK rising edge shall shift SDATA in LSB-first, with the first ADDR_BITS bits as address and the next DATA_BITS bits as data.
REQ-018 The bit counter shall saturate at ADDR_BITS+DATA_BITS+1 so that over-length frames are detected without wrap-around.
REQ-019 SHIFT -> COMMIT on a synchronized SL rising edge; COMMIT -> IDLE unconditionally after 1 cycle.
REQ-020 In COMMIT, a frame with exactly ADDR_BITS+DATA_BITS bits and address 0..3 is valid. In that cycle: pulse wr_valid, drive wr_addr/wr_data, update the addressed register.
REQ-021 Address map: 0 Oper=data[6:0]; 1 Ctrl=data[6:0]; 2 Clamp=data[7:0]; 3 VGA_Gain=data[9:0]; unused upper data bits are ignored.
REQ-022 In COMMIT, a short frame, an over-length frame, or address 4..7 shall pulse frame_err, produce no wr_valid, and leave the registers unchanged.
REQ-023 An SCK rising edge in the same cycle as an SL rising edge shall be ignored, because SL takes priority.
REQ-024 SCK edges while in IDLE shall be ignored.
REQ-025 busy = (state==SHIFT).
REQ-026 Latency: wr_valid/frame_err shall be asserted exactly 1 sys_clk after the cycle in which the synchronized SL rising edge is detected.
REQ-027 Register outputs shall change only in the COMMIT cycle.

Reset
REQ-028 While rst_n=0: state IDLE; Oper, Ctrl, Clamp, VGA_Gain, wr_addr, wr_data, bit counter and shift register all 0; wr_valid, frame_err and busy all 0.
REQ-029 Synchronizer flops shall reset to 1 for SL and 0 for SCK and SDATA, so that no false edge occurs at reset release.
REQ-030 Reset asserted mid-frame shall abandon the frame. After release, an SL already low shall not start a frame, and the next SL falling edge is required.

Configuration
REQ-031 Macro AD9945_SPI_RX_ERRCNT_EN, when defined, shall add output err_cnt (8 bits, reset 0). err_cnt increments on each frame_err and saturates at 255.
REQ-032 Without AD9945_SPI_RX_ERRCNT_EN, the err_cnt port and its counter shall be absent; all other behaviour is identical.

Structure
REQ-033 Package ad9945_pkg shall hold the address constants (ADDR_OPER=0, ADDR_CTRL=1, ADDR_CLAMP=2, ADDR_VGA=3), the default field widths, and the FSM state encoding.
REQ-034 The synchronizer/edge detector shall be sub-module ad9945_sync, instantiated three times.

Verification
REQ-035 Reset, then frame addr=3, data=12'h2A5 -> wr_valid 1 cycle, wr_addr=3, wr_data=12'h2A5, VGA_Gain=10'h2A5, other registers 0.
REQ-036 Four back-to-back frames writing Oper=7'h55, Ctrl=7'h2A, Clamp=8'hC3, VGA_Gain=10'h3FF -> all four registers hold those values, with 4 wr_valid pulses and 0 frame_err pulses.
REQ-037 A 14-bit frame, then a 16-bit frame, then addr=5 -> 3 frame_err pulses and no register change; with AD9945_SPI_RX_ERRCNT_EN, err_cnt=3.
REQ-038 rst_n pulsed low after 7 SCK bits of a frame -> registers 0 and no wr_valid; the next full frame addr=2, data=8'h81 sets Clamp=8'h81.
REQ-039 SCK toggles while SL is high, then a valid frame addr=0, data=7'h11 -> only that frame is accepted, giving Oper=7'h11.
REQ-040 With AD9945_SPI_RX_ERRCNT_EN, 300 bad frames -> err_cnt saturates at 255.
